// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, FSM state and flag-index definitions shared by alu_seq_unit
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd5;
  localparam logic [3:0] OP_SHL   = 4'd6;
  localparam logic [3:0] OP_SHR   = 4'd7;
  localparam logic [3:0] OP_ROL   = 4'd8;
  localparam logic [3:0] OP_ROR   = 4'd9;
  localparam logic [3:0] OP_INC   = 4'd10;
  localparam logic [3:0] OP_DEC   = 4'd11;
  localparam logic [3:0] OP_MUL   = 4'd12;
  localparam logic [3:0] OP_CMP   = 4'd13;
  localparam logic [3:0] OP_PASSA = 4'd14;
  localparam logic [3:0] OP_PASSB = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_V = 2;
  localparam int FLG_N = 3;

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - N-step shift-add unsigned multiplier, one partial product per cycle
module alu_seq_mul #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] prod
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N);

  logic [2*N-1:0] mcand_q, mcand_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;

  // done is held for the one cycle after the last step so the caller can take prod
  assign done = busy_q && (cnt_q == LAST);
  assign busy = busy_q;
  assign prod = acc_q;

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = {{N{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
      end else begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - registered 16-op ALU with valid/ready on both sides and one result buffer
module alu_seq_unit #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   sel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out,
  output logic [3:0]   flags,
  output logic         out_valid,
  input  logic         out_ready
);

  import alu_pkg::*;

  localparam int SHW = $clog2(N);
  localparam logic [SHW:0] NW = (SHW+1)'(N);

  state_t         state_q, state_d;
  logic [N-1:0]   out_q, out_d;
  logic [3:0]     flags_q, flags_d;

  logic           accept, mul_start, mul_busy, mul_done;
  logic [2*N-1:0] mul_prod;
  logic [SHW-1:0] sh;
  logic [SHW:0]   inv;
  logic [N-1:0]   rhs, res;
  logic [N:0]     sum, diff, shl_w, shr_w;
  logic           c, v;
  logic [3:0]     flg;

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (sel == OP_MUL);
  assign out       = out_q;
  assign flags     = flags_q;
  assign out_valid = (state_q == ST_DONE);

  alu_seq_mul #(.N(N)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (A),
    .b     (B),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  // INC/DEC reuse the ADD/SUB adders with a constant 1 operand
  always_comb begin
    sh    = B[SHW-1:0];
    inv   = NW - {1'b0, sh};
    rhs   = ((sel == OP_INC) || (sel == OP_DEC)) ? N'(1) : B;
    sum   = {1'b0, A} + {1'b0, rhs};
    diff  = {1'b0, A} - {1'b0, rhs};
    shl_w = {1'b0, A} << sh;
    shr_w = {A, 1'b0} >> sh;
    res   = '0;
    c     = 1'b0;
    v     = 1'b0;
    case (sel)
      OP_ADD, OP_INC: begin
        res = sum[N-1:0];
        c   = sum[N];
        v   = (A[N-1] == rhs[N-1]) && (sum[N-1] != A[N-1]);
      end
      OP_SUB, OP_DEC, OP_CMP: begin
        res = diff[N-1:0];
        c   = diff[N];
        v   = (A[N-1] != rhs[N-1]) && (diff[N-1] != A[N-1]);
      end
      OP_AND:   res = A & B;
      OP_OR:    res = A | B;
      OP_XOR:   res = A ^ B;
      OP_NOT:   res = ~A;
      OP_SHL: begin
        res = shl_w[N-1:0];
        c   = shl_w[N];
      end
      OP_SHR: begin
        res = shr_w[N:1];
        c   = shr_w[0];
      end
      OP_ROL:   res = (A << sh) | (A >> inv);
      OP_ROR:   res = (A >> sh) | (A << inv);
      OP_PASSA: res = A;
      OP_PASSB: res = B;
      default:  res = '0;
    endcase
    flg[FLG_Z] = (res == '0);
    flg[FLG_N] = res[N-1];
    flg[FLG_C] = c;
    flg[FLG_V] = v;
    // CMP flags come from the difference; only the visible result is zeroed
    if (sel == OP_CMP) res = '0;
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (sel == OP_MUL) begin
            state_d = ST_MUL;
          end else begin
            state_d = ST_DONE;
            out_d   = res;
            flags_d = flg;
          end
        end else if ((state_q == ST_DONE) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_busy && mul_done) begin
          state_d        = ST_DONE;
          out_d          = mul_prod[N-1:0];
          flags_d        = '0;
          flags_d[FLG_Z] = (mul_prod[N-1:0] == '0);
          flags_d[FLG_N] = mul_prod[N-1];
          flags_d[FLG_C] = |mul_prod[2*N-1:N];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - directed and randomized bench for alu_seq_unit with a scoreboard model
module tb_alu_seq_unit;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic [3:0] sel;
  logic       in_valid, in_ready;
  logic [7:0] out;
  logic [3:0] flags;
  logic       out_valid, out_ready;

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];
  bit rand_done;

  always #5 clk = ~clk;

  alu_seq_unit #(.N(8)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .flags(flags), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Result model: {neg, ovf, carry, zero, out}, computed with plain integer arithmetic
  function automatic logic [11:0] ref_model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    int ua, ub, sa, sb, sh, r, full;
    logic c, v, z, n;
    ua = x; ub = y;
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    sh = ub % 8;
    r = 0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin full = ua + ub; r = full % 256; c = (full > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      OP_SUB, OP_CMP: begin r = (ua - ub + 256) % 256; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
      OP_AND: r = ua & ub;
      OP_OR:  r = ua | ub;
      OP_XOR: r = ua ^ ub;
      OP_NOT: r = 255 - ua;
      OP_SHL: begin r = (ua << sh) % 256; if (sh != 0) c = (((ua << sh) / 256) % 2 == 1); end
      OP_SHR: begin r = ua >> sh; if (sh != 0) c = (((ua >> (sh - 1)) % 2) == 1); end
      OP_ROL: r = ((ua << sh) | (ua >> (8 - sh))) % 256;
      OP_ROR: r = ((ua >> sh) | (ua << (8 - sh))) % 256;
      OP_INC: begin r = (ua + 1) % 256; c = (ua == 255); v = (sa == 127); end
      OP_DEC: begin r = (ua + 255) % 256; c = (ua == 0); v = (sa == -128); end
      OP_MUL: begin full = ua * ub; r = full % 256; c = (full > 255); end
      OP_PASSA: r = ua;
      default: r = ub;
    endcase
    z = (r == 0);
    n = (r >= 128);
    if (op == OP_CMP) r = 0;
    return {n, v, c, z, 8'(r)};
  endfunction

  // Scoreboard: sampled mid-cycle, which shows what the next rising edge will do
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("sb_underflow", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          logic [11:0] e;
          e = exp_q.pop_front();
          check("sb_out", out, e[7:0]);
          check("sb_flags", flags, e[11:8]);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(sel, a, b));
    end
  end

  task automatic issue(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    int k;
    k = 0;
    sel = op; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("accept_timeout", k < 200, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; sel = 4'($urandom);
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] eo, input logic [3:0] ef);
    int k;
    issue(op, x, y);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_out"}, out, eo);
    check({tag, "_flags"}, flags, ef);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat, busy_cnt;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sel = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", out, 0);
    check("rst_flags", flags, 0);
    check("rst_valid", out_valid, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    run("add", OP_ADD, 8'hF0, 8'h20, 8'h10, 4'b0010);
    @(posedge clk); #1;

    // SUB and CMP on consecutive edges
    sel = OP_SUB; a = 8'h80; b = 8'h01; in_valid = 1'b1;
    @(posedge clk); #1;
    sel = OP_CMP; a = 8'h05; b = 8'h05;
    check("sub_out", out, 8'h7F);
    check("sub_flags", flags, 4'b0100);
    check("sub_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("cmp_valid", out_valid, 1);
    check("cmp_out", out, 8'h00);
    check("cmp_flags", flags, 4'b0001);
    @(posedge clk); #1;

    // MUL latency and in_ready blackout
    sel = OP_MUL; a = 8'h0D; b = 8'h0B; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!out_valid && lat < 40) begin
      if (!in_ready) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    check("mul_latency", lat, 9);
    check("mul_in_ready_low", busy_cnt, 9);
    check("mul_out", out, 8'h8F);
    check("mul_flags", flags, 4'b1000);
    run("mul_ovf", OP_MUL, 8'h10, 8'h10, 8'h00, 4'b0011);

    run("rol", OP_ROL, 8'h81, 8'h01, 8'h03, 4'b0000);
    run("ror", OP_ROR, 8'h81, 8'h01, 8'hC0, 4'b1000);
    run("shl", OP_SHL, 8'h81, 8'h01, 8'h02, 4'b0010);
    run("shr0", OP_SHR, 8'h01, 8'h00, 8'h01, 4'b0000);
    run("rol0", OP_ROL, 8'hA5, 8'h00, 8'hA5, 4'b1000);
    run("inc_ff", OP_INC, 8'hFF, 8'h00, 8'h00, 4'b0011);
    run("dec_0", OP_DEC, 8'h00, 8'h00, 8'hFF, 4'b1010);
    @(posedge clk); #1;

    // Backpressure: result held, new op refused until out_ready returns
    out_ready = 1'b0;
    issue(OP_ADD, 8'h12, 8'h34);
    sel = OP_SUB; a = 8'h50; b = 8'h20; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_out", out, 8'h46);
      check("bp_flags", flags, 4'b0000);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_out", out, 8'h30);
    check("bp_next_valid", out_valid, 1);
    @(posedge clk); #1;

    // Reset in the middle of a multiply
    sel = OP_MUL; a = 8'h33; b = 8'h07; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("midmul_rst_out", out, 0);
    check("midmul_rst_flags", flags, 0);
    check("midmul_rst_valid", out_valid, 0);
    check("midmul_rst_in_ready", in_ready, 1);
    run("mul_after_rst", OP_MUL, 8'h0D, 8'h0B, 8'h8F, 4'b1000);

    // Randomized traffic with random consumer stalls
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 250; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
          end
          issue(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Registered, parametrised successor to the team's combinational n-bit ALU. Same 16-op sel[3:0] encoding space; adds clocked operation, a valid/ready handshake on both sides, status flags and a multi-cycle shift-add multiplier.
- Sits between an operand-issue stage and a result consumer. Buffers exactly one result.

Parameters:
- N, 8, operand/result width. Must be a power of two, N ≥ 4.
- SHW, $clog2(N), shift-amount width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- A  in  N  operand A
- B  in  N  operand B
- sel  in  4  opcode
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept this cycle
- out  out  N  result
- flags  out  4  {neg, ovf, carry, zero}
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result

Behaviour:
- Reset: on rst high at a clk edge, state=IDLE, out=0, flags=0, out_valid=0, multiplier regs=0. rst overrides everything, including mid-MUL; the in-flight op is discarded.
- Accept: a transfer occurs when in_valid && in_ready at a clk edge. A, B and sel are captured on that edge and need not be held afterwards.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Back-to-back single-cycle ops give 1 result per cycle.
- States:
  - IDLE: on accept, a non-MUL op goes to DONE; MUL goes to MUL.
  - MUL: runs exactly N cycles (one shift-add step per cycle), then goes to DONE.
  - DONE: out_valid=1. If out_ready with no new accept, go to IDLE. If out_ready with an accept, load the new result (non-MUL) or go to MUL. If !out_ready, hold out/flags/out_valid stable.
- Latency: non-MUL ops give out_valid on the edge after accept. MUL gives out_valid N+1 edges after accept.
- Opcodes and results:
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT A
  - 6 SHL: A<<B[SHW-1:0]
  - 7 SHR logical: A>>B[SHW-1:0]
  - 8 ROL: A rotated left by B[SHW-1:0]
  - 9 ROR: A rotated right by B[SHW-1:0]
  - 10 INC: A+1
  - 11 DEC: A-1
  - 12 MUL: low N bits of A*B (unsigned)
  - 13 CMP: out=0, flags from A-B
  - 14 PASS A
  - 15 PASS B
- Flags:
  - zero = (result==0). For CMP, zero = (A==B).
  - neg = result[N-1]. For CMP, neg = (A-B)[N-1].
  - carry:
    - ADD/INC: carry-out.
    - SUB/DEC/CMP: borrow (1 when A<B unsigned; for DEC, when A==0).
    - SHL: last bit shifted out. SHR: last bit shifted out. Shift by 0 gives carry=0.
    - MUL: 1 when the upper N product bits are nonzero.
    - All others: 0.
  - ovf: signed overflow for ADD/SUB/INC/DEC/CMP. 0 for all other ops.
- Boundaries:
  - ROL/ROR by 0 → out = A.
  - INC of all-ones → out=0, carry=1, zero=1.
  - in_valid while in MUL or DONE with !out_ready → not accepted (in_ready=0).
- Outputs are registered. No combinational path from A/B/sel to out. in_ready depends combinationally on out_ready only.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_ADD … OP_PASSB)
  - state encoding (ST_IDLE, ST_MUL, ST_DONE)
  - flag bit indices (FLG_Z=0, FLG_C=1, FLG_V=2, FLG_N=3)
- One sub-module, alu_seq_mul: N-cycle shift-add multiplier.
  - Ports: clk, rst, start, a, b, busy, done, prod[2N-1:0].
  - The top FSM drives start and consumes done.
- Combinational op/flag logic stays in the top level.

Test Plan:
- Reset: rst=1 for 2 cycles, including once mid-MUL → out=0, flags=0, out_valid=0, in_ready=1 on the next cycle.
- ADD, N=8: A=8'hF0, B=8'h20 → next cycle out=8'h10, carry=1, ovf=0, zero=0, neg=0, out_valid=1.
- SUB then CMP, back-to-back with out_ready=1:
  - SUB A=8'h80, B=8'h01 → out=8'h7F, ovf=1, carry=0.
  - CMP A=8'h05, B=8'h05 → out=0, zero=1.
  - Results on consecutive cycles.
- MUL: A=8'h0D, B=8'h0B → in_ready=0 for 9 cycles, then out=8'h8F, carry=0, out_valid exactly 9 edges after accept. A=8'h10, B=8'h10 → out=0, carry=1, zero=1.
- Shifts/rotates:
  - ROL A=8'h81, B=1 → 8'h03.
  - ROR A=8'h81, B=1 → 8'hC0.
  - SHL A=8'h81, B=1 → 8'h02, carry=1.
  - SHR A=8'h01, B=0 → 8'h01, carry=0.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD → out/flags/out_valid stable, in_ready=0, new in_valid ignored. Raise out_ready → result consumed and a pending op accepted on the same edge.
